pin_unlock_ctrl: RTL and testbench

//  Keypad PIN checker that drives the door lock's unlock_signal input.
//  - Collects digit strobes from the keypad scanner and compares them against a stored code.
//  - Emits a one-cycle unlock_signal pulse on a match.
//  - Counts failed attempts and enforces a timed lockout after MAX_FAILS.
//  - Sits between the keypad scanner and the door lock, one instance per room terminal.

---
 rtl/pin_pkg.sv | 14 +
 rtl/cycle_timer.sv | 33 +++
 rtl/pin_unlock_ctrl.sv | 145 ++++++++++++++
 tb/tb_pin_unlock_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pin_pkg.sv
// rtl/pin_pkg.sv - shared key codes and controller states for the PIN unlock controller
package pin_pkg;

  localparam logic [3:0] KEY_DIGIT_MAX = 4'h9;
  localparam logic [3:0] KEY_CLEAR     = 4'hA;
  localparam logic [3:0] KEY_ENTER     = 4'hB;

  typedef enum logic [1:0] {IDLE, ENTRY, CHECK, LOCKOUT} pin_state_t;

  function automatic logic is_digit(input logic [3:0] key);
    return key <= KEY_DIGIT_MAX;
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// rtl/cycle_timer.sv - loadable down-counter; done flags the last cycle of a cyc-long interval
module cycle_timer #(
  parameter int unsigned MAX_CYC = 100,
  parameter int          W       = $clog2(MAX_CYC + 1)
) (
  input  logic         FPGA_CLK1_50,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] cyc,
  output logic         busy,
  output logic         done
);

  logic [W-1:0] cnt;

  // A start restarts the interval even if one is already running.
  always_ff @(posedge FPGA_CLK1_50) begin
    if (reset) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      cnt  <= cyc;
      busy <= (cyc != '0);
    end else if (busy) begin
      cnt <= cnt - W'(1);
      if (cnt == W'(1))
        busy <= 1'b0;
    end
  end

  assign done = busy && (cnt == W'(1));

endmodule

// File: rtl/pin_unlock_ctrl.sv
// rtl/pin_unlock_ctrl.sv - keypad PIN checker with unlock pulse, fail counting and timed lockout
module pin_unlock_ctrl
  import pin_pkg::*;
#(
  parameter int unsigned           CODE_LEN          = 4,
  parameter logic [4*CODE_LEN-1:0] DEFAULT_CODE      = 'h1234,
  parameter int unsigned           ENTRY_TIMEOUT_CYC = 250_000_000,
  parameter int unsigned           MAX_FAILS         = 3,
  parameter int unsigned           LOCKOUT_CYC       = 1_500_000_000
) (
  input  logic                  FPGA_CLK1_50,
  input  logic                  reset,
  input  logic                  key_valid,
  input  logic [3:0]            key_code,
  input  logic                  code_load,
  input  logic [4*CODE_LEN-1:0] code_in,
  output logic                  unlock_signal,
  output logic                  fail_pulse,
  output logic                  locked_out,
  output logic [3:0]            digit_count
);

  localparam int unsigned BW   = 4 * CODE_LEN;
  localparam int unsigned TMAX = (ENTRY_TIMEOUT_CYC > LOCKOUT_CYC) ? ENTRY_TIMEOUT_CYC : LOCKOUT_CYC;
  localparam int          TW   = $clog2(TMAX + 1);
  localparam int          FCW  = $clog2(MAX_FAILS + 1);

  pin_state_t    state, state_nxt;
  logic [BW-1:0] code_buf, code_buf_nxt;
  logic [BW-1:0] stored, stored_nxt;
  logic [3:0]    dcnt_nxt;
  logic [FCW-1:0] fail_cnt, fail_cnt_nxt;
  logic          unlock_nxt, fail_nxt, locked_nxt;
  logic          timer_start, timer_busy, timer_done;
  logic [TW-1:0] timer_cyc;
  logic          key_digit, match;

  // Entry timeout and lockout never overlap, so one timer serves both.
  cycle_timer #(.MAX_CYC(TMAX), .W(TW)) u_timer (
    .FPGA_CLK1_50 (FPGA_CLK1_50),
    .reset        (reset),
    .start        (timer_start),
    .cyc          (timer_cyc),
    .busy         (timer_busy),
    .done         (timer_done)
  );

  assign key_digit = key_valid && is_digit(key_code);
  assign match     = (digit_count == 4'(CODE_LEN)) && (code_buf == stored);

  always_ff @(posedge FPGA_CLK1_50) begin
    if (reset) begin
      state         <= IDLE;
      code_buf      <= '0;
      stored        <= DEFAULT_CODE;
      digit_count   <= '0;
      fail_cnt      <= '0;
      unlock_signal <= 1'b0;
      fail_pulse    <= 1'b0;
      locked_out    <= 1'b0;
    end else begin
      state         <= state_nxt;
      code_buf      <= code_buf_nxt;
      stored        <= stored_nxt;
      digit_count   <= dcnt_nxt;
      fail_cnt      <= fail_cnt_nxt;
      unlock_signal <= unlock_nxt;
      fail_pulse    <= fail_nxt;
      locked_out    <= locked_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    code_buf_nxt = code_buf;
    stored_nxt   = stored;
    dcnt_nxt     = digit_count;
    fail_cnt_nxt = fail_cnt;
    unlock_nxt   = 1'b0;
    fail_nxt     = 1'b0;
    locked_nxt   = locked_out;
    timer_start  = 1'b0;
    timer_cyc    = TW'(ENTRY_TIMEOUT_CYC);

    case (state)
      IDLE: begin
        if (code_load) begin
          stored_nxt = code_in;
        end else if (key_digit) begin
          code_buf_nxt = BW'(key_code);
          dcnt_nxt     = 4'd1;
          timer_start  = 1'b1;
          state_nxt    = ENTRY;
        end
      end
      ENTRY: begin
        if (key_digit) begin
          // Surplus digits are dropped but still count as activity.
          if (digit_count < 4'(CODE_LEN)) begin
            code_buf_nxt = BW'({code_buf, key_code});
            dcnt_nxt     = digit_count + 4'd1;
          end
          timer_start = 1'b1;
        end else if (key_valid && key_code == KEY_CLEAR) begin
          code_buf_nxt = '0;
          dcnt_nxt     = '0;
          state_nxt    = IDLE;
        end else if (key_valid && key_code == KEY_ENTER) begin
          state_nxt = CHECK;
        end else if (timer_done || !timer_busy) begin
          code_buf_nxt = '0;
          dcnt_nxt     = '0;
          state_nxt    = IDLE;
        end
      end
      CHECK: begin
        code_buf_nxt = '0;
        dcnt_nxt     = '0;
        state_nxt    = IDLE;
        if (match) begin
          unlock_nxt   = 1'b1;
          fail_cnt_nxt = '0;
        end else begin
          fail_nxt     = 1'b1;
          fail_cnt_nxt = fail_cnt + FCW'(1);
          if (fail_cnt == FCW'(MAX_FAILS - 1)) begin
            locked_nxt  = 1'b1;
            timer_start = 1'b1;
            timer_cyc   = TW'(LOCKOUT_CYC);
            state_nxt   = LOCKOUT;
          end
        end
      end
      LOCKOUT: begin
        if (timer_done || !timer_busy) begin
          locked_nxt   = 1'b0;
          fail_cnt_nxt = '0;
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pin_unlock_ctrl.sv
// tb/tb_pin_unlock_ctrl.sv - directed bench with a behavioural PIN-lock model checked every cycle
module tb_pin_unlock_ctrl;

  localparam int ETO  = 100;
  localparam int LCK  = 200;
  localparam int MAXF = 3;

  logic        FPGA_CLK1_50 = 1'b0;
  logic        reset        = 1'b1;
  logic        key_valid    = 1'b0;
  logic [3:0]  key_code     = 4'h0;
  logic        code_load    = 1'b0;
  logic [15:0] code_in      = 16'h0;
  logic        unlock_signal, fail_pulse, locked_out;
  logic [3:0]  digit_count;

  always #10 FPGA_CLK1_50 = ~FPGA_CLK1_50;

  pin_unlock_ctrl #(
    .CODE_LEN(4), .DEFAULT_CODE(16'h1234),
    .ENTRY_TIMEOUT_CYC(ETO), .MAX_FAILS(MAXF), .LOCKOUT_CYC(LCK)
  ) dut (
    .FPGA_CLK1_50 (FPGA_CLK1_50),
    .reset        (reset),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .code_load    (code_load),
    .code_in      (code_in),
    .unlock_signal(unlock_signal),
    .fail_pulse   (fail_pulse),
    .locked_out   (locked_out),
    .digit_count  (digit_count)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Behavioural model: digits held in a queue, lockout as a remaining-cycle count.
  int          m_digits[$];
  logic [15:0] m_stored;
  bit          m_entering, m_checking, model_on;
  int          m_idle, m_lock_left, m_fails;
  bit          e_unlock, e_fail, e_locked;

  int n_unlock = 0, n_fail = 0, locked_cycles = 0, last_unlock_cyc = -1, enter_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] digits_value();
    logic [15:0] v = 16'h0;
    foreach (m_digits[i]) v = (v << 4) | 16'(m_digits[i]);
    return v;
  endfunction

  task automatic clear_entry();
    m_digits.delete();
    m_entering = 0;
    m_idle     = 0;
  endtask

  task automatic model_step();
    e_unlock = 0;
    e_fail   = 0;
    if (reset) begin
      clear_entry();
      m_checking = 0; m_lock_left = 0; m_fails = 0;
      m_stored = 16'h1234; e_locked = 0;
    end else if (m_lock_left > 0) begin
      m_lock_left--;
      if (m_lock_left == 0) begin e_locked = 0; m_fails = 0; end
    end else if (m_checking) begin
      m_checking = 0;
      if (m_digits.size() == 4 && digits_value() == m_stored) begin
        e_unlock = 1; m_fails = 0;
      end else begin
        e_fail = 1; m_fails++;
        if (m_fails == MAXF) begin e_locked = 1; m_lock_left = LCK; end
      end
      clear_entry();
    end else if (!m_entering) begin
      if (code_load) m_stored = code_in;
      else if (key_valid && key_code <= 4'd9) begin
        m_digits.push_back(int'(key_code));
        m_entering = 1; m_idle = 0;
      end
    end else begin
      if (key_valid && key_code <= 4'd9) begin
        if (m_digits.size() < 4) m_digits.push_back(int'(key_code));
        m_idle = 0;
      end else if (key_valid && key_code == 4'hA) begin
        clear_entry();
      end else if (key_valid && key_code == 4'hB) begin
        m_checking = 1; m_entering = 0;
      end else begin
        m_idle++;
        if (m_idle == ETO) clear_entry();
      end
    end
  endtask

  always @(negedge FPGA_CLK1_50) begin
    if (model_on) begin
      check("unlock_signal", 32'(unlock_signal), 32'(e_unlock));
      check("fail_pulse", 32'(fail_pulse), 32'(e_fail));
      check("locked_out", 32'(locked_out), 32'(e_locked));
      check("digit_count", 32'(digit_count), 32'(m_digits.size()));
      check("unlock_fail_exclusive", 32'(unlock_signal & fail_pulse), 32'd0);
      if (unlock_signal === 1'b1) begin n_unlock++; last_unlock_cyc = cyc; end
      if (fail_pulse === 1'b1) n_fail++;
      if (locked_out === 1'b1) locked_cycles++;
    end
  end

  task automatic tick();
    @(posedge FPGA_CLK1_50);
    cyc++;
    model_step();
    model_on = 1;
    #1;
  endtask

  task automatic press(input logic [3:0] k);
    key_valid = 1'b1; key_code = k;
    tick();
    key_valid = 1'b0;
    tick();
  endtask

  task automatic enter_pin(input logic [15:0] pin);
    for (int i = 3; i >= 0; i--) press(pin[i*4 +: 4]);
    enter_cyc = cyc;
    press(4'hB);
    tick();
  endtask

  task automatic load_code(input logic [15:0] c);
    code_in = c; code_load = 1'b1;
    tick();
    code_load = 1'b0;
    tick();
  endtask

  int u0, f0, w;

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_unlock", 32'(unlock_signal), 0);
    check("rst_fail", 32'(fail_pulse), 0);
    check("rst_locked", 32'(locked_out), 0);
    check("rst_digits", 32'(digit_count), 0);

    // Correct default PIN, with the enter-to-grant latency pinned.
    u0 = n_unlock; f0 = n_fail;
    enter_pin(16'h1234);
    check("s1_unlock_count", n_unlock - u0, 1);
    check("s1_fail_count", n_fail - f0, 0);
    check("s1_latency", last_unlock_cyc - enter_cyc, 2);

    // Three wrong PINs lock out; correct PIN ignored until release.
    u0 = n_unlock; f0 = n_fail; locked_cycles = 0;
    repeat (3) enter_pin(16'h1235);
    check("s2_fail_count", n_fail - f0, 3);
    check("s2_locked", 32'(locked_out), 1);
    enter_pin(16'h1234);
    check("s2_no_unlock_locked", n_unlock - u0, 0);
    w = 0;
    while (locked_out === 1'b1 && w < 400) begin tick(); w++; end
    check("s2_lock_released", 32'(locked_out), 0);
    check("s2_lock_length", locked_cycles, 200);
    enter_pin(16'h1234);
    check("s2_unlock_after", n_unlock - u0, 1);

    // Entry timeout, then a short entry fails.
    press(4'h1); press(4'h2);
    check("s3_two_digits", 32'(digit_count), 2);
    repeat (101) tick();
    check("s3_timeout_digits", 32'(digit_count), 0);
    f0 = n_fail;
    press(4'h3); press(4'h4); press(4'hB); tick();
    check("s3_short_fail", n_fail - f0, 1);
    check("s3_model_fails", m_fails, 1);
    check("s3_not_locked", 32'(locked_out), 0);

    // Surplus digits saturate; clear discards a partial entry.
    u0 = n_unlock;
    press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h5);
    check("s4_saturate", 32'(digit_count), 4);
    press(4'hB); tick();
    check("s4_unlock_sat", n_unlock - u0, 1);
    press(4'h9); press(4'hA);
    check("s4_cleared", 32'(digit_count), 0);
    enter_pin(16'h1234);
    check("s4_unlock_after_clear", n_unlock - u0, 2);

    // PIN load in IDLE; ignored in ENTRY; wins over a coincident key.
    u0 = n_unlock; f0 = n_fail;
    load_code(16'h4321);
    enter_pin(16'h1234);
    check("s5_old_pin_fails", n_fail - f0, 1);
    enter_pin(16'h4321);
    check("s5_new_pin_unlocks", n_unlock - u0, 1);
    press(4'h4);
    code_in = 16'h5678; code_load = 1'b1;
    tick();
    code_load = 1'b0;
    press(4'h3); press(4'h2); press(4'h1); press(4'hB); tick();
    check("s5_load_in_entry_ignored", n_unlock - u0, 2);
    code_in = 16'h1234; code_load = 1'b1; key_valid = 1'b1; key_code = 4'h7;
    tick();
    code_load = 1'b0; key_valid = 1'b0;
    tick();
    check("s5_coincide_key_dropped", 32'(digit_count), 0);
    enter_pin(16'h1234);
    check("s5_coincide_load_taken", n_unlock - u0, 3);

    // Reset mid-lockout restores the default PIN.
    load_code(16'h4321);
    repeat (3) enter_pin(16'h1111);
    check("s6_locked", 32'(locked_out), 1);
    repeat (50) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("s6_reset_unlocks", 32'(locked_out), 0);
    tick();
    u0 = n_unlock;
    enter_pin(16'h1234);
    check("s6_default_pin", n_unlock - u0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
